score_display: RTL and testbench
================================

# score_display

Converts the 8-bit game score into three decimal digits and drives a per-pixel "score glyph" flag for the colour mapper. It reads the score register kept by the food/tile-map block. Conversion runs once per frame, so the value shown never changes mid-frame. The block sits between the food block's score output and the colour mapper, alongside the maze/food draw path.

## Interface
Parameters:
- X0, 10'd32: left edge of the score field, in pixels.
- Y0, 10'd384: top edge of the score field, below the 20x11 tile maze.
- SCALE_LOG2, 1: glyph magnification as a power of two. Each glyph is (8<<SCALE_LOG2) wide by (16<<SCALE_LOG2) tall.

Ports:
- Clk, input, 1: 50 MHz system clock.
- Reset, input, 1: synchronous, active-high. Clock is Clk.
- score_in, input, 8: binary score from the food block, range 0..255.
- frame_start, input, 1: one-cycle pulse at the start of vertical blank.
- DrawX, input, 10: current pixel x.
- DrawY, input, 10: current pixel y.
- is_score_pixel, output, 1: 1 = pixel is a lit glyph pixel. Registered.
- score_bcd, output, 12: displayed digits {hundreds, tens, ones}. BCD, committed value.
- conv_busy, output, 1: high while a conversion is in progress.

## Operation
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - On frame_start, snapshot score_in into an 8-bit shift register.
  - Clear the 12-bit BCD accumulator and the 3-bit iteration counter.
  - Go to SHIFT.
- SHIFT (double-dabble), once per cycle:
  - Add 3 to every BCD nibble that is >= 5.
  - Then shift {bcd, bin} left by one bit.
  - Increment the counter.
  - After the 8th shift, go to COMMIT.
- COMMIT: copy the accumulator to score_bcd, then return to IDLE.
- conv_busy = 1 in SHIFT and COMMIT.
- frame_start arriving outside IDLE is ignored. No queueing.
- score_in changing after the snapshot has no effect until the next frame_start.
- Render region: DrawX in [X0, X0+3*(8<<SCALE_LOG2)) and DrawY in [Y0, Y0+(16<<SCALE_LOG2)).
  - dx = DrawX-X0 and dy = DrawY-Y0.
  - Digit slot = dx >> (3+SCALE_LOG2): slot 0 = hundreds, slot 2 = ones.
  - Glyph column = (dx >> SCALE_LOG2) & 7.
  - Glyph row = dy >> SCALE_LOG2, range 0..15.
- Glyph lookup: ROM indexed by {digit[3:0], row[3:0]} returns an 8-bit row.
  - Bit 7 is the leftmost column.
  - Column 7 of every glyph is blank, which provides inter-digit spacing.
- Leading-zero suppression:
  - The hundreds slot is blank when the hundreds digit is 0.
  - The tens slot is blank when both hundreds and tens are 0.
  - The ones slot is always drawn.
- is_score_pixel = in-region AND slot not suppressed AND ROM bit set.
- Outside the region, is_score_pixel = 0.
- Arithmetic: all region compares are unsigned 10-bit. DrawX < X0 never wraps into the region.

## Timing
- Reset values:
  - state IDLE.
  - score_bcd 12'h000.
  - conv_busy 0.
  - is_score_pixel 0.
  - Shift register and counter 0.
- Reset mid-conversion aborts the conversion. score_bcd returns to 12'h000, so "0" is displayed.
- Conversion latency:
  - frame_start is sampled at edge N.
  - SHIFT runs on edges N+1..N+8.
  - COMMIT is at edge N+9.
  - score_bcd changes after edge N+9.
  - conv_busy is high from after edge N through edge N+9.
- Pixel latency is exactly one cycle. is_score_pixel after edge N reflects DrawX/DrawY sampled at edge N. This matches the food block's registered is_food.
- A reset asserted together with frame_start wins.

## Structure
- Shared package score_pkg holds:
  - the FSM state enum;
  - the BCD_W = 12 constant;
  - the NUM_DIGITS = 3 constant;
  - the GLYPH_W = 8 and GLYPH_H = 16 constants.
- Sub-module score_digit_rom holds the combinational 160x8 glyph table, with an input for {digit, row} and an 8-bit row output. Digit codes 10..15 return 8'h00.
- The top level holds the FSM, the double-dabble datapath, the region and slot decode, and the output register.

## Test plan
- Reset, then scan the ones-digit cell → glyph '0' pixels match the ROM. The hundreds and tens cells give is_score_pixel = 0 everywhere, and score_bcd = 12'h000.
- score_in = 137, pulse frame_start → conv_busy high for 9 cycles. score_bcd = 12'h137 after edge N+9 and not before.
- score_in = 255 → score_bcd = 12'h255. score_in = 5 → 12'h005, with only the ones cell lit.
- score_in = 40 → the tens cell is drawn as '4' and the hundreds cell is blank. score_in = 100 → all three cells drawn, with the tens cell showing '0'.
- Change score_in from 10 to 99 at N+3, and pulse frame_start at N+4 → score_bcd = 12'h010. The pulse is ignored, and the next frame_start yields 12'h099.
- Assert Reset at N+5 during a conversion of 200 → score_bcd = 12'h000 and conv_busy = 0 after that edge. DrawX = X0-1 and DrawX = X0+48 (SCALE_LOG2 = 1) → is_score_pixel = 0.

Source files
------------

// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and constants for the score display block
package score_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    localparam int BCD_W      = 12;
    localparam int NUM_DIGITS = 3;
    localparam int GLYPH_W    = 8;
    localparam int GLYPH_H    = 16;

    // Double-dabble pre-shift correction for one BCD nibble
    function automatic logic [3:0] dabble_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/score_display_if.sv
// rtl/score_display_if.sv - score input, raster position and glyph/BCD outputs
interface score_display_if;
    logic [7:0]  score_in;
    logic        frame_start;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        is_score_pixel;
    logic [11:0] score_bcd;
    logic        conv_busy;

    modport master (
        output score_in, frame_start, DrawX, DrawY,
        input  is_score_pixel, score_bcd, conv_busy
    );

    modport slave (
        input  score_in, frame_start, DrawX, DrawY,
        output is_score_pixel, score_bcd, conv_busy
    );
endinterface

// File: rtl/score_digit_rom.sv
// rtl/score_digit_rom.sv - 160x8 seven-segment style digit glyph table
module score_digit_rom (
    input  logic [7:0] addr,
    output logic [7:0] row_bits
);
    // Segment order {a,b,c,d,e,f,g}; bars are two pixels thick, column 7 stays blank
    localparam logic [7:0] BAR   = 8'hFE;
    localparam logic [7:0] LEFT  = 8'hC0;
    localparam logic [7:0] RIGHT = 8'h06;

    logic [3:0] digit;
    logic [3:0] row;
    logic [6:0] seg;
    logic [7:0] upper;
    logic [7:0] lower;

    assign digit = addr[7:4];
    assign row   = addr[3:0];

    always_comb begin
        seg = 7'b0000000;
        case (digit)
            4'd0: seg = 7'b1111110;
            4'd1: seg = 7'b0110000;
            4'd2: seg = 7'b1101101;
            4'd3: seg = 7'b1111001;
            4'd4: seg = 7'b0110011;
            4'd5: seg = 7'b1011011;
            4'd6: seg = 7'b1011111;
            4'd7: seg = 7'b1110000;
            4'd8: seg = 7'b1111111;
            4'd9: seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
    end

    assign upper = (seg[1] ? LEFT : 8'h00) | (seg[5] ? RIGHT : 8'h00);
    assign lower = (seg[2] ? LEFT : 8'h00) | (seg[4] ? RIGHT : 8'h00);

    always_comb begin
        row_bits = 8'h00;
        case (row)
            4'd1, 4'd2:                 row_bits = seg[6] ? BAR : upper;
            4'd3, 4'd4, 4'd5, 4'd6:     row_bits = upper;
            4'd7:                       row_bits = seg[0] ? BAR : upper;
            4'd8:                       row_bits = seg[0] ? BAR : lower;
            4'd9, 4'd10, 4'd11, 4'd12:  row_bits = lower;
            4'd13, 4'd14:               row_bits = seg[3] ? BAR : lower;
            default:                    row_bits = 8'h00;
        endcase
    end
endmodule

// File: rtl/score_display.sv
// rtl/score_display.sv - once-per-frame binary-to-BCD score and glyph pixel flag
module score_display
    import score_pkg::*;
#(
    parameter logic [9:0] X0         = 10'd32,
    parameter logic [9:0] Y0         = 10'd384,
    parameter int         SCALE_LOG2 = 1
) (
    input  logic           Clk,
    input  logic           Reset,
    score_display_if.slave bus
);
    localparam int         CELL_W = GLYPH_W << SCALE_LOG2;
    localparam int         CELL_H = GLYPH_H << SCALE_LOG2;
    localparam logic [9:0] X_END  = 10'(int'(X0) + NUM_DIGITS * CELL_W);
    localparam logic [9:0] Y_END  = 10'(int'(Y0) + CELL_H);

    conv_state_t      state_q, state_d;
    logic [7:0]       bin_q;
    logic [BCD_W-1:0] acc_q;
    logic [BCD_W-1:0] acc_adj;
    logic [BCD_W-1:0] score_bcd_q;
    logic [2:0]       cnt_q;
    logic             pix_q;
    logic             pix_d;

    assign acc_adj = {dabble_adjust(acc_q[11:8]),
                      dabble_adjust(acc_q[7:4]),
                      dabble_adjust(acc_q[3:0])};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.frame_start) state_d = SHIFT;
            SHIFT:   if (cnt_q == 3'd7)   state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            score_bcd_q <= '0;
            pix_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            case (state_q)
                IDLE: begin
                    if (bus.frame_start) begin
                        bin_q <= bus.score_in;
                        acc_q <= '0;
                        cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    {acc_q, bin_q} <= {acc_adj, bin_q} << 1;
                    cnt_q          <= cnt_q + 3'd1;
                end
                COMMIT:  score_bcd_q <= acc_q;
                default: ;
            endcase
        end
    end

    // Raster decode; offsets are only meaningful once in_region has bounded them
    logic [9:0] dx, dy;
    logic       in_region;
    logic [1:0] slot;
    logic [2:0] col;
    logic [3:0] row;
    logic [3:0] digit;
    logic       suppress;
    logic [7:0] rom_row;
    logic       unused_draw;

    assign dx        = bus.DrawX - X0;
    assign dy        = bus.DrawY - Y0;
    assign in_region = (bus.DrawX >= X0) && (bus.DrawX < X_END) &&
                       (bus.DrawY >= Y0) && (bus.DrawY < Y_END);
    assign slot      = dx[3+SCALE_LOG2 +: 2];
    assign col       = dx[SCALE_LOG2 +: 3];
    assign row       = dy[SCALE_LOG2 +: 4];
    assign unused_draw = ^{dx, dy};

    always_comb begin
        digit = score_bcd_q[3:0];
        case (slot)
            2'd0:    digit = score_bcd_q[11:8];
            2'd1:    digit = score_bcd_q[7:4];
            default: digit = score_bcd_q[3:0];
        endcase
    end

    assign suppress = ((slot == 2'd0) && (score_bcd_q[11:8] == 4'd0)) ||
                      ((slot == 2'd1) && (score_bcd_q[11:4] == 8'd0));

    score_digit_rom u_rom (
        .addr     ({digit, row}),
        .row_bits (rom_row)
    );

    assign pix_d = in_region && !suppress && rom_row[3'd7 - col];

    assign bus.is_score_pixel = pix_q;
    assign bus.score_bcd      = score_bcd_q;
    assign bus.conv_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - randomized self-checking bench for score_display
module tb_score_display;
    localparam int X0 = 32;
    localparam int Y0 = 384;
    localparam int SC = 2;

    // Bit d set when digit d lights that segment
    localparam logic [9:0] SEG_A = 10'b1111101101;
    localparam logic [9:0] SEG_B = 10'b1110011111;
    localparam logic [9:0] SEG_C = 10'b1111111011;
    localparam logic [9:0] SEG_D = 10'b1101101101;
    localparam logic [9:0] SEG_E = 10'b0101000101;
    localparam logic [9:0] SEG_F = 10'b1101110001;
    localparam logic [9:0] SEG_G = 10'b1101111100;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   shown = 0;

    always #10 Clk = ~Clk;

    score_display_if bus ();

    score_display dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        return 32'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    function automatic bit glyph_lit(input int d, input int col, input int row);
        bit lit;
        bit bar, left, right, top, bot;
        bar   = (col <= 6);
        left  = (col <= 1);
        right = (col >= 5) && (col <= 6);
        top   = (row >= 1) && (row <= 7);
        bot   = (row >= 8) && (row <= 14);
        lit = (SEG_A[d] && row >= 1 && row <= 2 && bar) ||
              (SEG_G[d] && row >= 7 && row <= 8 && bar) ||
              (SEG_D[d] && row >= 13 && row <= 14 && bar) ||
              (SEG_F[d] && top && left) || (SEG_B[d] && top && right) ||
              (SEG_E[d] && bot && left) || (SEG_C[d] && bot && right);
        return lit;
    endfunction

    function automatic bit model_pix(input int v, input int x, input int y);
        int dx, dy, slot, col, row, d;
        dx = x - X0;
        dy = y - Y0;
        if (dx < 0 || dx >= 3 * 8 * SC || dy < 0 || dy >= 16 * SC) return 1'b0;
        slot = dx / (8 * SC);
        col  = (dx / SC) % 8;
        row  = dy / SC;
        if (slot == 0 && v < 100) return 1'b0;
        if (slot == 1 && v < 10) return 1'b0;
        d = (slot == 0) ? v / 100 : (slot == 1) ? (v / 10) % 10 : v % 10;
        return glyph_lit(d, col, row);
    endfunction

    task automatic scan_region(input string tag);
        bit pend = 1'b0;
        bit exp_prev = 1'b0;
        for (int y = Y0 - 2; y < Y0 + 16 * SC + 2; y++) begin
            for (int x = X0 - 2; x < X0 + 24 * SC + 2; x++) begin
                @(negedge Clk);
                if (pend) chk(tag, 32'(bus.is_score_pixel), 32'(exp_prev));
                bus.DrawX = 10'(x);
                bus.DrawY = 10'(y);
                exp_prev  = model_pix(shown, x, y);
                pend      = 1'b1;
            end
        end
        @(negedge Clk);
        chk(tag, 32'(bus.is_score_pixel), 32'(exp_prev));
    endtask

    task automatic probe(input string tag, input int x, input int y);
        @(negedge Clk);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        @(negedge Clk);
        chk(tag, 32'(bus.is_score_pixel), 32'(model_pix(shown, x, y)));
    endtask

    task automatic convert(input int v);
        @(negedge Clk);
        bus.score_in    = 8'(v);
        bus.frame_start = 1'b1;
        @(negedge Clk);
        bus.frame_start = 1'b0;
        bus.score_in    = 8'($urandom);
        for (int i = 0; i < 9; i++) begin
            chk("busy_during", 32'(bus.conv_busy), 32'd1);
            chk("bcd_hold", 32'(bus.score_bcd), to_bcd(shown));
            @(negedge Clk);
        end
        chk("busy_after", 32'(bus.conv_busy), 32'd0);
        chk("bcd_commit", 32'(bus.score_bcd), to_bcd(v));
        shown = v;
    endtask

    initial begin
        bus.score_in    = 8'd0;
        bus.frame_start = 1'b0;
        bus.DrawX       = 10'd0;
        bus.DrawY       = 10'd0;
        repeat (3) @(negedge Clk);
        bus.frame_start = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        bus.frame_start = 1'b0;
        chk("rst_busy", 32'(bus.conv_busy), 32'd0);
        chk("rst_bcd", 32'(bus.score_bcd), 32'h000);
        chk("rst_pix", 32'(bus.is_score_pixel), 32'd0);
        scan_region("scan_0");

        convert(137);
        scan_region("scan_137");
        convert(255);
        convert(5);
        scan_region("scan_5");
        convert(40);
        scan_region("scan_40");
        convert(100);
        scan_region("scan_100");

        // Snapshot isolation and ignored mid-conversion frame_start
        @(negedge Clk);
        bus.score_in    = 8'd10;
        bus.frame_start = 1'b1;
        @(negedge Clk);
        bus.frame_start = 1'b0;
        repeat (2) @(negedge Clk);
        bus.score_in = 8'd99;
        @(negedge Clk);
        bus.frame_start = 1'b1;
        @(negedge Clk);
        bus.frame_start = 1'b0;
        repeat (5) @(negedge Clk);
        chk("snap_busy", 32'(bus.conv_busy), 32'd0);
        chk("snap_bcd", 32'(bus.score_bcd), 32'h010);
        shown = 10;
        @(negedge Clk);
        chk("no_queue", 32'(bus.conv_busy), 32'd0);
        convert(99);

        // Reset aborts a conversion in flight
        @(negedge Clk);
        bus.score_in    = 8'd200;
        bus.frame_start = 1'b1;
        @(negedge Clk);
        bus.frame_start = 1'b0;
        repeat (4) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("abort_bcd", 32'(bus.score_bcd), 32'h000);
        chk("abort_busy", 32'(bus.conv_busy), 32'd0);
        shown = 0;
        repeat (12) @(negedge Clk);
        chk("abort_stay", 32'(bus.score_bcd), 32'h000);

        convert(208);
        probe("edge_x0", X0, Y0 + 2);
        chk("edge_x0_lit", 32'(bus.is_score_pixel), 32'd1);
        probe("left_out", X0 - 1, Y0 + 2);
        chk("left_out_zero", 32'(bus.is_score_pixel), 32'd0);
        probe("right_out", X0 + 48, Y0 + 2);
        chk("right_out_zero", 32'(bus.is_score_pixel), 32'd0);
        probe("x_zero", 0, Y0 + 2);
        probe("below", X0 + 2, Y0 + 32);

        for (int n = 0; n < 8; n++) begin
            convert(int'($urandom_range(0, 255)));
            for (int k = 0; k < 150; k++) begin
                probe("rand_pix", int'($urandom_range(X0 - 4, X0 + 51)),
                      int'($urandom_range(Y0 - 4, Y0 + 35)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
